// File: rtl/ccff_loader.sv
// Streams bitstream words MSB-first into a configuration flop chain, optionally
// comparing the chain tail against the bits sent to verify a previous load.
module ccff_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              check_en,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [7:0]        err_cnt,
  output logic              isol_n
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t            state, state_nxt;
  logic              chk;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] sreg;
  logic [BW-1:0]     bits_left;
  logic              chain_full, word_empty, miss, mismatch_nxt;

  // The bit on the head this cycle is the last one the chain needs.
  assign chain_full   = prog_clk_en && (bit_cnt == LAST_BIT);
  assign word_empty   = (bits_left == '0);
  assign miss         = prog_clk_en && chk && (ccff_tail != ccff_head);
  assign mismatch_nxt = mismatch | miss;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (word_valid) state_nxt = SHIFT;
      SHIFT: begin
        if (chain_full)      state_nxt = DONE;
        else if (word_empty) state_nxt = FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    word_ready = (state == FETCH);
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

  // Head and clock enable are registered; both default low so the head is
  // quiet whenever the chain is not shifting.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chk         <= 1'b0;
      bit_cnt     <= '0;
      sreg        <= '0;
      bits_left   <= '0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
      mismatch    <= 1'b0;
      err_cnt     <= '0;
      isol_n      <= 1'b0;
    end else begin
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
      if (prog_clk_en) bit_cnt <= bit_cnt + CNT_W'(1);
      if (miss) begin
        mismatch <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            chk      <= check_en;
            bit_cnt  <= '0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
            isol_n   <= 1'b0;
          end
        end
        FETCH: begin
          if (word_valid) begin
            ccff_head   <= word_data[WORD_W-1];
            prog_clk_en <= 1'b1;
            sreg        <= word_data << 1;
            bits_left   <= BW'(WORD_W - 1);
          end
        end
        SHIFT: begin
          // Include this cycle's compare so a failure on the final bit keeps isolation.
          if (chain_full) begin
            isol_n <= ~mismatch_nxt;
          end else if (!word_empty) begin
            ccff_head   <= sreg[WORD_W-1];
            prog_clk_en <= 1'b1;
            sreg        <= sreg << 1;
            bits_left   <= bits_left - BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: directed table, reset/start corner cases
// and randomized passes against a queue-based model of the configuration chain.
module tb_ccff_loader;

  localparam int WW = 8;
  localparam int CL = 20;

  logic          prog_clk = 1'b0;
  logic          prog_reset = 1'b1;
  logic          start = 1'b0;
  logic          check_en = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready, ccff_head, prog_clk_en, ccff_tail;
  logic          busy, done, mismatch, isol_n;
  logic [7:0]    err_cnt;

  ccff_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .check_en(check_en),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .prog_clk_en(prog_clk_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .mismatch(mismatch), .err_cnt(err_cnt), .isol_n(isol_n)
  );

  always #5 prog_clk = ~prog_clk;

  // Physical chain outside the DUT: shifts on every enabled edge, never reset.
  logic [CL-1:0] chain = '0;
  always @(posedge prog_clk) if (prog_clk_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  int errors = 0;
  int checks = 0;

  // Expected chain contents, index 0 = bit currently at the tail.
  bit chain_q[$];
  bit [7:0] wds[3];

  typedef struct {
    bit       chk;
    bit [7:0] w0, w1, w2;
    int       gap;
    bit       exp_mis;
    int       exp_err;
    bit       exp_isol;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int pick_gap(input int mode);
    return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
  endfunction

  // Errors a verify pass of wds would see against the current chain contents.
  function automatic int model_errs();
    bit s[$];
    int e = 0;
    for (int w = 0; w < 3; w++)
      for (int b = WW - 1; b >= 0; b--) s.push_back(wds[w][b]);
    for (int k = 0; k < CL; k++) if (s[k] != chain_q[k]) e++;
    return e;
  endfunction

  task automatic do_pass(input string tag, input bit chk, input int gap_mode, input bit spam,
                         input int stop_after, input bit exp_mis, input int exp_err,
                         input bit exp_isol);
    bit exp_s[$];
    int shifts = 0, dn = 0, viol = 0, wi = 0, cyc = 0, post = 0, gap, nbits;
    bit isol_d = 0, stopped = 0;
    logic [31:0] got_v = '0, exp_v = '0;
    for (int w = 0; w < 3; w++)
      for (int b = WW - 1; b >= 0; b--) exp_s.push_back(wds[w][b]);
    @(negedge prog_clk);
    start = 1'b1; check_en = chk;
    @(negedge prog_clk);
    start = 1'b0; check_en = 1'($urandom_range(0, 1));
    gap = pick_gap(gap_mode);
    while (cyc < 400) begin
      if (prog_clk_en) begin
        got_v = {got_v[30:0], ccff_head};
        shifts++;
      end else if (ccff_head) viol++;
      if (done) begin dn++; isol_d = isol_n; end
      if (stop_after > 0 && shifts == stop_after) begin stopped = 1; break; end
      if (dn > 0) begin post++; if (post == 3) break; end
      word_valid = 1'b0;
      if (word_ready && wi < 3) begin
        if (gap > 0) gap--;
        else begin
          word_valid = 1'b1; word_data = wds[wi]; wi++; gap = pick_gap(gap_mode);
        end
      end
      start = (spam && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge prog_clk);
      cyc++;
    end
    start = 1'b0; word_valid = 1'b0;
    nbits = (stop_after > 0) ? stop_after : CL;
    for (int k = 0; k < nbits; k++) exp_v = {exp_v[30:0], exp_s[k]};
    check({tag, "_shifts"}, shifts, nbits);
    check({tag, "_stream"}, got_v, exp_v);
    check({tag, "_head_idle"}, viol, 0);
    if (stop_after > 0) begin
      prog_reset = 1'b1;
      @(negedge prog_clk);
      check({tag, "_rst_outs"},
            {busy, done, prog_clk_en, ccff_head, word_ready, mismatch, isol_n, err_cnt}, '0);
      prog_reset = 1'b0;
    end else begin
      check({tag, "_done_pulses"}, dn, 1);
      check({tag, "_isol_at_done"}, isol_d, exp_isol);
      check({tag, "_isol_after"}, isol_n, exp_isol);
      check({tag, "_mismatch"}, mismatch, exp_mis);
      check({tag, "_err_cnt"}, err_cnt, exp_err);
      check({tag, "_busy_idle"}, busy, 0);
    end
    if (!stopped || stop_after > 0)
      for (int k = 0; k < nbits; k++) begin
        void'(chain_q.pop_front());
        chain_q.push_back(exp_s[k]);
      end
  endtask

  initial begin
    int e;
    bit c;
    for (int k = 0; k < CL; k++) chain_q.push_back(1'b0);
    tbl[0] = '{0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 1};
    tbl[1] = '{1, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 1};
    tbl[2] = '{1, 8'hA5, 8'h3C, 8'hF1, 1, 0, 0, 1};
    tbl[3] = '{1, 8'hA5, 8'h3C, 8'hE0, 0, 1, 1, 0};
    tbl[4] = '{0, 8'hA5, 8'h3C, 8'hF0, 5, 0, 0, 1};
    tbl[5] = '{1, 8'hA5, 8'h3C, 8'hF0, 5, 0, 0, 1};

    repeat (3) @(negedge prog_clk);
    check("reset_outs",
          {busy, done, prog_clk_en, ccff_head, word_ready, mismatch, isol_n, err_cnt}, '0);

    // Reset wins over a simultaneous start.
    prog_reset = 1'b1; start = 1'b1;
    @(negedge prog_clk);
    check("rst_prio_busy", busy, 0);
    prog_reset = 1'b0; start = 1'b0;
    @(negedge prog_clk);
    check("rst_prio_idle", {busy, word_ready}, 0);

    foreach (tbl[i]) begin
      wds[0] = tbl[i].w0; wds[1] = tbl[i].w1; wds[2] = tbl[i].w2;
      do_pass($sformatf("tbl%0d", i), tbl[i].chk, tbl[i].gap, 1'b0, 0,
              tbl[i].exp_mis, tbl[i].exp_err, tbl[i].exp_isol);
    end

    // Start pulses while busy must not spawn a second pass.
    do_pass("spam", 1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b1);

    // Mid-word reset during a failing verify, then a fresh pass.
    wds[0] = 8'h5A; wds[1] = 8'hC3; wds[2] = 8'h0F;
    do_pass("rst11", 1'b1, 0, 1'b0, 11, 1'b0, 0, 1'b0);
    e = model_errs();
    do_pass("after_rst", 1'b1, 0, 1'b0, 0, e > 0, e, e == 0);

    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 3; w++) wds[w] = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      e = c ? model_errs() : 0;
      do_pass($sformatf("rnd%0d", r), c, -1, 1'($urandom_range(0, 1)), 0,
              e > 0, e, e == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
